// File: rtl/mvb_item_packer_pkg.sv
// Shared constants, types and helpers for the MVB item packer.
// Item width and counts here are defaults; modules override per instance.
package mvb_item_packer_pkg;

  localparam int DEF_RX_ITEMS   = 4;
  localparam int DEF_TX_ITEMS   = 2;
  localparam int DEF_ITEM_WIDTH = 64;
  localparam int CNT_WIDTH      = $clog2(DEF_RX_ITEMS + 1);
  localparam int MAX_ITEMS      = 32;

  typedef logic [DEF_ITEM_WIDTH-1:0] item_t;

  function automatic int unsigned popcount(
    input logic [MAX_ITEMS-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_ITEMS; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  // Low-aligned mask with the lowest n bits set.
  function automatic logic [MAX_ITEMS-1:0] thermo(
    input int unsigned n
  );
    logic [MAX_ITEMS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_ITEMS; i++) begin
      if (i < n) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/mvb_item_packer_if.sv
// RX/TX MVB handshake bundle of the item packer.
// slave = packer side, master = producer/consumer side.
interface mvb_item_packer_if
  import mvb_item_packer_pkg::*;
#(
  parameter int RX_ITEMS   = DEF_RX_ITEMS,
  parameter int TX_ITEMS   = DEF_TX_ITEMS,
  parameter int ITEM_WIDTH = DEF_ITEM_WIDTH
);

  logic [RX_ITEMS*ITEM_WIDTH-1:0] rx_data;
  logic [RX_ITEMS-1:0]            rx_vld;
  logic                           rx_src_rdy;
  logic                           rx_dst_rdy;

  logic [TX_ITEMS*ITEM_WIDTH-1:0] tx_data;
  logic [TX_ITEMS-1:0]            tx_vld;
  logic                           tx_src_rdy;
  logic                           tx_dst_rdy;

  modport master (
    output rx_data,
    output rx_vld,
    output rx_src_rdy,
    input  rx_dst_rdy,
    input  tx_data,
    input  tx_vld,
    input  tx_src_rdy,
    output tx_dst_rdy
  );

  modport slave (
    input  rx_data,
    input  rx_vld,
    input  rx_src_rdy,
    output rx_dst_rdy,
    output tx_data,
    output tx_vld,
    output tx_src_rdy,
    input  tx_dst_rdy
  );

endinterface

// File: rtl/mvb_item_compact.sv
// Combinational compaction of valid items into low indices,
// preserving index order; unused output slots are zero.
module mvb_item_compact
  import mvb_item_packer_pkg::*;
#(
  parameter int N  = DEF_RX_ITEMS,
  parameter int W  = DEF_ITEM_WIDTH,
  parameter int CW = CNT_WIDTH
) (
  input  logic [N*W-1:0] data,
  input  logic [N-1:0]   vld,
  output logic [N*W-1:0] cdata,
  output logic [CW-1:0]  cnt
);

  always_comb begin
    int k;
    cdata = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      if (vld[i]) begin
        cdata[k*W +: W] = data[i*W +: W];
        k++;
      end
    end
  end

  assign cnt = CW'(popcount(MAX_ITEMS'(vld)));

endmodule

// File: rtl/mvb_item_packer.sv
// MVB item packer: compacts sparse RX words into dense TX words.
// Optional item statistics counter: MVB_ITEM_PACKER_STATS_EN.
module mvb_item_packer
  import mvb_item_packer_pkg::*;
#(
`ifdef MVB_ITEM_PACKER_STATS_EN
  parameter int STAT_WIDTH = 32,
`endif
  parameter int RX_ITEMS   = DEF_RX_ITEMS,
  parameter int TX_ITEMS   = DEF_TX_ITEMS,
  parameter int ITEM_WIDTH = DEF_ITEM_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MVB_ITEM_PACKER_STATS_EN
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_items,
`endif
  mvb_item_packer_if.slave bus
);

  localparam int CW = $clog2(RX_ITEMS + 1);
  localparam int W  = ITEM_WIDTH;

  logic [W-1:0]  item_q [RX_ITEMS];
  logic [W-1:0]  item_d [RX_ITEMS];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] sent;
  logic [CW-1:0] shift;
  logic          tx_fire;
  logic          rx_fire;

  logic [RX_ITEMS*W-1:0] cdata;
  logic [CW-1:0]         ccnt;

  mvb_item_compact #(
    .N  (RX_ITEMS),
    .W  (W),
    .CW (CW)
  ) u_compact (
    .data  (bus.rx_data),
    .vld   (bus.rx_vld),
    .cdata (cdata),
    .cnt   (ccnt)
  );

  assign sent = (cnt_q > CW'(TX_ITEMS))
              ? CW'(TX_ITEMS) : cnt_q;

  assign bus.tx_src_rdy = (cnt_q != '0);
  assign bus.tx_vld =
    TX_ITEMS'(thermo(32'(sent)));

  for (genvar j = 0; j < TX_ITEMS; j++) begin
    : g_tx
    assign bus.tx_data[j*W +: W] = item_q[j];
  end

  assign tx_fire = bus.tx_src_rdy & bus.tx_dst_rdy;

  // Accept only when the buffer is empty after this cycle's drain.
  assign bus.rx_dst_rdy = rst_n & (
    (cnt_q == '0) |
    ((cnt_q <= CW'(TX_ITEMS)) & bus.tx_dst_rdy)
  );

  assign rx_fire = bus.rx_src_rdy & bus.rx_dst_rdy;

  always_comb begin
    int idx;
    idx   = 0;
    shift = tx_fire ? sent : '0;
    cnt_d = cnt_q - shift;
    for (int i = 0; i < RX_ITEMS; i++) begin
      idx = i + int'(shift);
      if (idx < RX_ITEMS) item_d[i] = item_q[idx];
      else                item_d[i] = '0;
    end
    if (rx_fire) begin
      cnt_d = ccnt;
      for (int i = 0; i < RX_ITEMS; i++) begin
        item_d[i] = cdata[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < RX_ITEMS; i++) begin
        item_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < RX_ITEMS; i++) begin
        item_q[i] <= item_d[i];
      end
    end
  end

`ifdef MVB_ITEM_PACKER_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (stat_clr) begin
      stat_q <= '0;
    end else if (tx_fire) begin
      stat_q <= stat_q + STAT_WIDTH'(sent);
    end
  end

  assign stat_items = stat_q;
`endif

endmodule
